// File: rtl/seq_unsigned_divider.sv
// Iterative radix-2 restoring unsigned divider.
// Divides a 2*WORD_SIZE-bit dividend by a WORD_SIZE-bit divisor, one quotient
// bit per clock, with valid/ready handshakes on the operand and result sides.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | waiting for operands, in_ready=1
//   S_CALC | shifting/subtracting, one quotient bit per cycle
//   S_DONE | result presented, out_valid=1 until the consumer takes it
module seq_unsigned_divider #(
  parameter int WORD_SIZE = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*WORD_SIZE-1:0]   dividend,
  input  logic [WORD_SIZE-1:0]     divisor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_SIZE-1:0]     quotient,
  output logic [WORD_SIZE-1:0]     remainder,
  output logic                     div_zero,
  output logic                     overflow
);

  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(WORD_SIZE + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_dvs;
  logic [CW-1:0]  r_cnt;

  logic [W-1:0]   w_hi;
  logic [W-1:0]   w_lo;
  logic           w_div_zero;
  logic           w_overflow;
  logic [W:0]     w_t;
  logic           w_ge;
  logic [W-1:0]   w_rem_next;
  logic [W-1:0]   w_quo_next;
  logic           w_last;

  assign w_hi       = dividend[2*W-1:W];
  assign w_lo       = dividend[W-1:0];
  assign w_div_zero = (divisor == '0);
  assign w_overflow = (w_hi >= divisor);

  // The partial remainder stays below the divisor, so W+1 bits hold the shifted value;
  // the difference always fits back into W bits, so the top bit can be dropped.
  assign w_t        = {r_rem, r_quo[W-1]};
  assign w_ge       = (w_t >= {1'b0, r_dvs});
  assign w_rem_next = w_ge ? (w_t[W-1:0] - r_dvs) : w_t[W-1:0];
  assign w_quo_next = {r_quo[W-2:0], w_ge};
  assign w_last     = (r_cnt == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_div_zero || w_overflow) w_state_next = S_DONE;
          else                          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else if (r_state == S_IDLE && in_valid) begin
      if (w_div_zero) begin
        quotient  <= '1;
        remainder <= '0;
        div_zero  <= 1'b1;
        overflow  <= 1'b0;
      end else if (w_overflow) begin
        quotient  <= '1;
        remainder <= '0;
        div_zero  <= 1'b0;
        overflow  <= 1'b1;
      end else begin
        r_rem <= w_hi;
        r_quo <= w_lo;
        r_dvs <= divisor;
        r_cnt <= CW'(WORD_SIZE);
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        quotient  <= w_quo_next;
        remainder <= w_rem_next;
        div_zero  <= 1'b0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Directed and randomized checks for seq_unsigned_divider at WORD_SIZE=23.
module tb_seq_unsigned_divider;

  localparam int W = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_zero;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  seq_unsigned_divider #(.WORD_SIZE(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           dz;
    logic           ov;
    int             edges;   // rising edges after the accepting edge until out_valid is seen
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands, wait for acceptance, scramble inputs, then wait for the result.
  task automatic do_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, output int edges);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("accept_timeout", 64'(g), 64'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = W'($urandom);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_ov_drop"}, 64'(out_valid), 64'(0));
    check({name, "_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    int edges;
    int seen;
    logic [63:0] prod;
    logic [W-1:0] hold_q, hold_r;

    prod = 64'h234567 * 64'h654321 + 64'h1234;
    vecs[0]  = '{prod[2*W-1:0],            23'h654321, 23'h234567, 23'h1234,   1'b0, 1'b0, W};
    vecs[1]  = '{46'd100,                  23'd7,      23'd14,     23'd2,      1'b0, 1'b0, W};
    vecs[2]  = '{46'd0,                    23'd5,      23'd0,      23'd0,      1'b0, 1'b0, W};
    vecs[3]  = '{46'd12345,                23'd0,      23'h7FFFFF, 23'd0,      1'b1, 1'b0, 0};
    vecs[4]  = '{{23'd9, 23'd0},           23'd9,      23'h7FFFFF, 23'd0,      1'b0, 1'b1, 0};
    vecs[5]  = '{46'h7FFFFF,               23'd1,      23'h7FFFFF, 23'd0,      1'b0, 1'b0, W};
    vecs[6]  = '{{23'd999, 23'h7FFFFF},    23'd1000,   23'h7FFFFF, 23'd999,    1'b0, 1'b0, W};
    vecs[7]  = '{{23'd1000, 23'd0},        23'd1000,   23'h7FFFFF, 23'd0,      1'b0, 1'b1, 0};
    vecs[8]  = '{{23'h7FFFFE, 23'h7FFFFF}, 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFE, 1'b0, 1'b0, W};
    vecs[9]  = '{46'd1000,                 23'd1000,   23'd1,      23'd0,      1'b0, 1'b0, W};
    vecs[10] = '{46'd999,                  23'd1000,   23'd0,      23'd999,    1'b0, 1'b0, W};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_quotient",  64'(quotient),  64'(0));
    check("rst_remainder", 64'(remainder), 64'(0));
    check("rst_div_zero",  64'(div_zero),  64'(0));
    check("rst_overflow",  64'(overflow),  64'(0));

    // Directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].dvd, vecs[i].dvs, edges);
      check($sformatf("v%0d_latency", i), 64'(edges),      64'(vecs[i].edges));
      check($sformatf("v%0d_quot", i),    64'(quotient),   64'(vecs[i].q));
      check($sformatf("v%0d_rem", i),     64'(remainder),  64'(vecs[i].r));
      check($sformatf("v%0d_dz", i),      64'(div_zero),   64'(vecs[i].dz));
      check($sformatf("v%0d_ov", i),      64'(overflow),   64'(vecs[i].ov));
      check($sformatf("v%0d_busy", i),    64'(in_ready),   64'(0));
      drain($sformatf("v%0d", i));
      check($sformatf("v%0d_keep_quot", i), 64'(quotient), 64'(vecs[i].q));
      check($sformatf("v%0d_keep_dz", i),   64'(div_zero), 64'(vecs[i].dz));
    end

    // Stall: result held for 10 cycles with out_ready low
    do_op(46'd100, 23'd7, edges);
    hold_q = quotient;
    hold_r = remainder;
    check("stall_q_value", 64'(hold_q), 64'(14));
    check("stall_r_value", 64'(hold_r), 64'(2));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_ov", k),   64'(out_valid), 64'(1));
      check($sformatf("stall%0d_ir", k),   64'(in_ready),  64'(0));
      check($sformatf("stall%0d_q", k),    64'(quotient),  64'(14));
      check($sformatf("stall%0d_r", k),    64'(remainder), 64'(2));
    end
    drain("stall");

    // Reset in the middle of CALC discards the operation
    @(negedge clk);
    in_valid = 1'b1;
    dividend = prod[2*W-1:0];
    divisor  = 23'h654321;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_in_ready",  64'(in_ready),  64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_quotient",  64'(quotient),  64'(0));
    check("midrst_remainder", 64'(remainder), 64'(0));
    check("midrst_flags",     64'({div_zero, overflow}), 64'(0));
    seen = 0;
    repeat (W + 5) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_result", 64'(seen), 64'(0));
    do_op(46'd100, 23'd7, edges);
    check("postrst_latency", 64'(edges),     64'(W));
    check("postrst_quot",    64'(quotient),  64'(14));
    check("postrst_rem",     64'(remainder), 64'(2));
    drain("postrst");

    // Randomized operations against the arithmetic golden model
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0]   dvs;
      logic [2*W-1:0] dvd;
      logic [63:0]    eq, er;
      logic           edz, eov;
      int             sel;
      sel = $urandom_range(0, 9);
      dvs = (sel < 3) ? W'($urandom_range(1, 255)) : W'($urandom_range(1, (1 << W) - 1));
      dvd = {W'($urandom % dvs), W'($urandom)};
      if (sel == 9) dvs = '0;
      if (sel == 8) dvd[2*W-1:W] = dvs;
      edz = (dvs == '0);
      eov = !edz && (dvd[2*W-1:W] >= dvs);
      if (edz || eov) begin
        eq = 64'h7FFFFF;
        er = 64'd0;
      end else begin
        eq = 64'(dvd) / 64'(dvs);
        er = 64'(dvd) % 64'(dvs);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(dvd, dvs, edges);
      check($sformatf("rnd%0d_quot", n),  64'(quotient),            eq);
      check($sformatf("rnd%0d_rem", n),   64'(remainder),           er);
      check($sformatf("rnd%0d_flags", n), 64'({div_zero, overflow}), 64'({edz, eov}));
      check($sformatf("rnd%0d_lat", n),   64'(edges),               64'((edz || eov) ? 0 : W));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
